sync_fifo_param: RTL
====================

# sync_fifo_param

Parametrised synchronous FIFO, the next-generation replacement for the team's fixed 8×16 circular FIFO. It adds configurable width and depth, concurrent read and write in one cycle, a live occupancy count, and programmable almost-full/almost-empty thresholds. It sits between producer and consumer blocks in the same clock domain and is the standard buffer for new datapaths.

## Interface
- WIDTH, default 8: data word width in bits, ≥1.
- DEPTH, default 16: number of entries. Power of two, ≥4.
- AF_LEVEL, default DEPTH-2: almost_full asserts when level ≥ AF_LEVEL.
- AE_LEVEL, default 2: almost_empty asserts when level ≤ AE_LEVEL.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset: synchronous, active-high.
- wr  in  1  write request.
- rd  in  1  read request.
- din  in  WIDTH  write data.
- dout  out  WIDTH  read data, registered.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- almost_full  out  1  level ≥ AF_LEVEL.
- almost_empty  out  1  level ≤ AE_LEVEL.
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was dropped (see Configuration).
- underflow  out  1  sticky: a read was dropped (see Configuration).

## Operation
- Pointers wptr and rptr are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0. The level register is $clog2(DEPTH)+1 bits wide.
- A write is accepted when wr && (!full || rd). An accepted write stores din at mem[wptr] and advances wptr by 1.
- A read is accepted when rd && !empty. An accepted read loads dout ← mem[rptr] and advances rptr by 1.
- Level update:
  - Write only: +1.
  - Read only: −1.
  - Both accepted, or neither: unchanged.
- Simultaneous rd && wr:
  - When empty: only the write is accepted. No fall-through; dout keeps its value.
  - When full: both are accepted. The read returns the oldest word, the new word takes the freed slot, and full stays asserted.
  - Otherwise: both are accepted and level is unchanged.
- dout holds its last value whenever no read is accepted.
- full, empty, almost_full and almost_empty are decoded combinationally from the level register only.
- Memory contents are not reset.

## Timing
- Reset values:
  - wptr = rptr = 0, level = 0, dout = 0.
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - overflow = underflow = 0.
- Read latency is 1 cycle: dout is valid in the cycle after the edge on which the read was accepted.
- Write-to-read latency is 1 cycle: a word written at edge N can be read at edge N+1 and appears on dout after edge N+1.
- Flags and level reflect all operations accepted at the previous edge; there is no combinational path from wr or rd to any output.
- If rst is asserted mid-burst, it wins over rd and wr at that edge. The FIFO is empty on the next cycle and data is discarded.
- A wrap at DEPTH-1 → 0 causes no bubble. Sustained rd && wr at any level 1..DEPTH-1 gives one word per cycle.

## Configuration
- Macro: FIFO_ERR_FLAGS_EN.
- Defined:
  - overflow sets on any edge with wr && full && !rd.
  - underflow sets on any edge with rd && empty.
  - Both are sticky until rst.
  - The dropped request changes no pointer, level or data.
- Undefined: overflow and underflow are tied to 0 and no error logic is generated. Dropped requests are still ignored silently.

## Structure
- Package fifo_pkg holds:
  - the ptr_t/level_t width helper functions, based on $clog2;
  - the default constants FIFO_DEF_WIDTH = 8 and FIFO_DEF_DEPTH = 16;
  - an elaboration check function that rejects a non-power-of-two DEPTH and AE_LEVEL ≥ AF_LEVEL.
- Sub-module fifo_mem_dp: a simple dual-port register array with one write port and one registered read port, parametrised by WIDTH and DEPTH. The top level owns pointers, level, flags and error logic.
- The updated fifo_if interface is parametrised by WIDTH and DEPTH and carries all ports above.

## Test plan
All scenarios use WIDTH=8, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2.
- Reset: pulse rst for 2 cycles → dout=0, empty=1, almost_empty=1, level=0, full=0.
- Fill: write 0x00..0x0F on 16 consecutive cycles.
  - almost_empty falls when level=3.
  - almost_full rises when level=14.
  - full=1 when level=16.
  - A 17th write of 0xAA is dropped and overflow=1 (macro defined).
- Drain: read 16 times → dout = 0x00..0x0F in order, each one cycle after its read. empty=1 after the last read. A 17th read is dropped, underflow=1 and dout holds 0x0F.
- Concurrent: at level 5, assert rd && wr for 40 cycles → level stays 5, data stays in order across two pointer wraps, no bubbles.
- Boundary concurrency:
  - Empty with rd && wr(0x55): level becomes 1 and dout is unchanged.
  - Full with rd && wr(0x77): the oldest word is returned, level stays 16, and 0x77 emerges last.
- Mid-operation reset: at level 9 with rd && wr active, assert rst for 1 cycle → level=0, empty=1, dout=0, error flags cleared. A subsequent write of 0x3C followed by a read returns 0x3C.

Source files
------------

// File: rtl/sync_fifo_param_pkg.sv
// fifo_pkg: shared constants and elaboration helpers for sync_fifo_param.
package fifo_pkg;

  localparam int FIFO_DEF_WIDTH = 8;
  localparam int FIFO_DEF_DEPTH = 16;

  // Pointer width: log2 of the depth, never narrower than one bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Level width: one extra bit so that DEPTH itself is representable.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Legal configuration: power-of-two depth of at least 4 and AE below AF.
  function automatic bit cfg_ok(input int depth, input int ae_level, input int af_level);
    return (depth >= 4) && ((depth & (depth - 1)) == 0) && (ae_level < af_level);
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// fifo_if: producer/consumer side of sync_fifo_param.
// master = the block talking to the FIFO, slave = the FIFO itself.
interface fifo_if
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_DEF_WIDTH,
  parameter int DEPTH = FIFO_DEF_DEPTH
);
  localparam int LW = level_width(DEPTH);

  logic             wr;
  logic             rd;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [LW-1:0]    level;
  logic             overflow;
  logic             underflow;

  modport master (
    output wr, rd, din,
    input  dout, full, empty, almost_full, almost_empty, level, overflow, underflow
  );

  modport slave (
    input  wr, rd, din,
    output dout, full, empty, almost_full, almost_empty, level, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param_mem_dp.sv
// fifo_mem_dp: register array with one write port and one registered read port.
// The read register resets to zero; the array itself is not reset.
module fifo_mem_dp
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_DEF_WIDTH,
  parameter int DEPTH = FIFO_DEF_DEPTH,
  localparam int AW   = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Store write data; no reset so the array maps onto plain flops or RAM.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read; a read and write to the same slot returns the old word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with occupancy count and
// almost-full/almost-empty thresholds. Optional sticky overflow/underflow
// flags are built when FIFO_ERR_FLAGS_EN is defined; otherwise tied low.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH    = FIFO_DEF_WIDTH,
  parameter int DEPTH    = FIFO_DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic  clk,
  input  logic  rst,
  fifo_if.slave fifo
);

  localparam int PW = ptr_width(DEPTH);
  localparam int LW = level_width(DEPTH);

  if (!cfg_ok(DEPTH, AE_LEVEL, AF_LEVEL)) begin : g_bad_cfg
    $error("sync_fifo_param: DEPTH must be a power of two >= 4 and AE_LEVEL < AF_LEVEL");
  end

  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic          w_full;
  logic          w_empty;
  logic          w_wr_acc;
  logic          w_rd_acc;

  // Status decoded from the level register only, so no path from wr/rd.
  assign w_full  = (r_level == LW'(DEPTH));
  assign w_empty = (r_level == '0);

  // A full FIFO still takes a write when a read frees the slot this edge.
  assign w_wr_acc = fifo.wr && (!w_full || fifo.rd);
  assign w_rd_acc = fifo.rd && !w_empty;

  // Pointer and occupancy bookkeeping; pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_wr_acc && !w_rd_acc) begin
        r_level <= r_level + 1'b1;
      end else if (w_rd_acc && !w_wr_acc) begin
        r_level <= r_level - 1'b1;
      end
    end
  end

  fifo_mem_dp #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_wr_acc),
    .i_waddr (r_wptr),
    .i_wdata (fifo.din),
    .i_re    (w_rd_acc),
    .i_raddr (r_rptr),
    .o_rdata (fifo.dout)
  );

  assign fifo.level        = r_level;
  assign fifo.full         = w_full;
  assign fifo.empty        = w_empty;
  assign fifo.almost_full  = (r_level >= LW'(AF_LEVEL));
  assign fifo.almost_empty = (r_level <= LW'(AE_LEVEL));

`ifdef FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  // Sticky error flags: remember any request dropped since the last reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (fifo.wr && w_full && !fifo.rd) begin
        r_overflow <= 1'b1;
      end
      if (fifo.rd && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign fifo.overflow  = r_overflow;
  assign fifo.underflow = r_underflow;
`else
  assign fifo.overflow  = 1'b0;
  assign fifo.underflow = 1'b0;
`endif

endmodule
